// File: rtl/ram_loader_pkg.sv
// ----------------------------------------------------------------------------
// ram_loader_pkg
// Items shared by ram_loader and word_packer: the loader FSM state type, the
// stream byte width and a helper that sizes the byte-lane index.
// ----------------------------------------------------------------------------
package ram_loader_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Width of a lane index for a word of 'bytes' lanes. It is never below
    // one bit, so a one-byte word still gets a legal vector.
    function automatic int idx_width(input int bytes);
        return (bytes > 1) ? $clog2(bytes) : 1;
    endfunction

endpackage

// File: rtl/word_packer.sv
// ----------------------------------------------------------------------------
// word_packer
// Steers stream bytes little-endian into the lanes of a W-bit word. Byte 0
// lands in bits [7:0], byte 1 in [15:8], and so on.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   byte_data  incoming stream byte
//   load_en    store byte_data into lane byte_idx, then advance byte_idx
//   clear      restart lane counting at lane 0 (has priority over load_en)
//   word       lanes stored so far
//   byte_idx   lane that the next accepted byte will fill
//   last_byte  byte_idx points at the top lane
// ----------------------------------------------------------------------------
module word_packer
    import ram_loader_pkg::*;
#(
    parameter int  W     = 32,
    localparam int BYTES = W / BYTE_W,
    localparam int IW    = idx_width(BYTES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] byte_data,
    input  logic              load_en,
    input  logic              clear,
    output logic [W-1:0]      word,
    output logic [IW-1:0]     byte_idx,
    output logic              last_byte
);

    assign last_byte = (byte_idx == IW'(BYTES - 1));

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before the clock edge, whatever the statement
    // order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (clear) begin
            byte_idx <= '0;
        end else if (load_en) begin
            for (int i = 0; i < BYTES; i++) begin
                if (byte_idx == IW'(i)) begin
                    word[i*BYTE_W +: BYTE_W] <= byte_data;
                end
            end
            byte_idx <= last_byte ? '0 : byte_idx + IW'(1);
        end
    end

endmodule

// File: rtl/ram_loader.sv
// ----------------------------------------------------------------------------
// ram_loader
// Takes a byte stream over a valid/ready handshake, packs it into W-bit
// words and writes the words to consecutive addresses of a distributed_ram
// through its write channel. Addresses wrap modulo L.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   start       begin a load (sampled only while idle)
//   base_addr   first word address, latched on start
//   num_words   number of words to load (0 completes at once), latched on start
//   byte_data   stream byte
//   byte_valid  byte_data is valid
//   byte_ready  loader takes a byte this cycle
//   wr_ena      RAM write strobe
//   addr        RAM word address
//   wr_data     RAM write data
//   busy        load in progress (every state except IDLE)
//   done        one-cycle pulse when the load completes
// ----------------------------------------------------------------------------
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int  W     = 32,
    parameter int  L     = 64,
    localparam int A     = $clog2(L),
    localparam int BYTES = W / BYTE_W,
    localparam int IW    = idx_width(BYTES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [A-1:0]      base_addr,
    input  logic [A:0]        num_words,
    input  logic [BYTE_W-1:0] byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_ena,
    output logic [A-1:0]      addr,
    output logic [W-1:0]      wr_data,
    output logic              busy,
    output logic              done
);

    state_t         state;
    logic [A:0]     num_q;
    logic [A:0]     word_cnt;

    logic           accept;
    logic           clear;
    logic [W-1:0]   word;
    logic [IW-1:0]  byte_idx;
    logic           last_byte;
    logic [W-1:0]   merged;
    logic [A-1:0]   addr_next;

    // byte_ready is high exactly in COLLECT, so this is the handshake.
    assign accept = byte_valid && byte_ready;
    assign clear  = (state == IDLE) && start;

    // The packer registers a lane one edge after it arrives. The byte that
    // completes a word is merged here so the write can follow on the very
    // next cycle.
    always_comb begin
        merged = word;
        for (int i = 0; i < BYTES; i++) begin
            if (byte_idx == IW'(i)) begin
                merged[i*BYTE_W +: BYTE_W] = byte_data;
            end
        end
    end

    // L need not be a power of two, so the wrap is explicit.
    assign addr_next = (addr == A'(L - 1)) ? '0 : addr + A'(1);

    word_packer #(.W(W)) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .byte_data (byte_data),
        .load_en   (accept),
        .clear     (clear),
        .word      (word),
        .byte_idx  (byte_idx),
        .last_byte (last_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            num_q      <= '0;
            word_cnt   <= '0;
            byte_ready <= 1'b0;
            wr_ena     <= 1'b0;
            addr       <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a state below re-asserts them.
            wr_ena <= 1'b0;
            done   <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (num_words != '0) begin
                            addr       <= base_addr;
                            num_q      <= num_words;
                            word_cnt   <= '0;
                            byte_ready <= 1'b1;
                            state      <= COLLECT;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                COLLECT: begin
                    if (accept && last_byte) begin
                        wr_data    <= merged;
                        wr_ena     <= 1'b1;
                        byte_ready <= 1'b0;
                        state      <= WRITE;
                    end
                end

                WRITE: begin
                    addr     <= addr_next;
                    word_cnt <= word_cnt + (A+1)'(1);
                    if (word_cnt + (A+1)'(1) == num_q) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        byte_ready <= 1'b1;
                        state      <= COLLECT;
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy       <= 1'b0;
                    byte_ready <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// ----------------------------------------------------------------------------
// tb_ram_loader
// Directed bench for ram_loader (W=32, L=64) with a behavioural RAM on the
// write channel. Expected words are written out by hand from the byte lists.
// ----------------------------------------------------------------------------
module tb_ram_loader;

    localparam int W = 32;
    localparam int L = 64;
    localparam int A = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [A-1:0]  base_addr = '0;
    logic [A:0]    num_words = '0;
    logic [7:0]    byte_data = '0;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic          wr_ena;
    logic [A-1:0]  addr;
    logic [W-1:0]  wr_data;
    logic          busy;
    logic          done;

    ram_loader #(.W(W), .L(L)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .num_words  (num_words),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_ena     (wr_ena),
        .addr       (addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Behavioural distributed_ram write port.
    logic [W-1:0] ram [L];
    always @(posedge clk) begin
        if (wr_ena) ram[addr] <= wr_data;
    end

    // Activity monitor, sampled on the falling edge.
    int           cyc = 0;
    int           wr_cnt = 0;
    int           done_cnt = 0;
    int           br_cnt = 0;
    int           gap_cnt = 0;
    logic [A-1:0] wr_addr [$];
    int           wr_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_ena) begin
            wr_cnt <= wr_cnt + 1;
            wr_addr.push_back(addr);
            wr_cyc.push_back(cyc);
        end
        if (done)       done_cnt <= done_cnt + 1;
        if (byte_ready) br_cnt   <= br_cnt + 1;
        // Busy but neither writing nor finishing means COLLECT: ready must be up.
        if (busy && !wr_ena && !done && !byte_ready) gap_cnt <= gap_cnt + 1;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] stim [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input int base, input int n);
        base_addr = A'(base);
        num_words = (A+1)'(n);
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    // Presents stim[first +: count]; stall=1 drives byte_valid as 1,0,0,1,0,0...
    task automatic feed(input int first, input int count, input bit stall, output bit ok);
        int  k = 0;
        int  j = 0;
        bit  acc;
        while (k < count && j < 300) begin
            byte_valid = stall ? (j % 3 == 0) : 1'b1;
            byte_data  = stim[first + k];
            acc        = byte_valid && byte_ready;
            step();
            if (acc) k++;
            j++;
        end
        byte_valid = 1'b0;
        ok = (k == count);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 20) begin
            step();
            lat++;
        end
    endtask

    initial begin
        bit ok;
        int lat;
        int w0, d0, b0, g0;

        for (int i = 0; i < L; i++) ram[i] = 32'hC0DE_0000 | W'(i);

        // ---------------- reset state ----------------
        step();
        step();
        check("reset_outputs", {byte_ready, wr_ena, busy, done, addr, wr_data}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("idle_busy", busy, 1'b0);

        // ---------------- reset mid-load ----------------
        stim = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
        start_load(0, 2);
        feed(0, 6, 1'b0, ok);
        check("rst_feed_ok", ok, 1'b1);
        check("rst_pre_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", {byte_ready, wr_ena, busy, done, addr, wr_data}, '0);
        w0 = wr_cnt;
        step();
        step();
        check("rst_ram0_kept", ram[0], 32'h1122_3344);
        check("rst_ram1_init", ram[1], 32'hC0DE_0001);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        check("rst_no_more_writes", wr_cnt - w0, 0);

        // ---------------- basic load (fresh start after reset) ----------------
        stim = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        w0 = wr_cnt; d0 = done_cnt;
        start_load(0, 2);
        feed(0, 8, 1'b0, ok);
        check("basic_feed_ok", ok, 1'b1);
        wait_done(lat);
        check("basic_done_seen", done, 1'b1);
        check("basic_busy_with_done", busy, 1'b1);
        step();
        check("basic_busy_after", {busy, done}, 2'b00);
        step();
        check("basic_wr_count", wr_cnt - w0, 2);
        check("basic_done_count", done_cnt - d0, 1);
        if (wr_cnt - w0 == 2) begin
            check("basic_wr_spacing", wr_cyc[w0+1] - wr_cyc[w0], 5);
            check("basic_wr_addr0", wr_addr[w0], 0);
            check("basic_wr_addr1", wr_addr[w0+1], 1);
        end
        check("basic_ram0", ram[0], 32'h1234_5678);
        check("basic_ram1", ram[1], 32'hDEAD_BEEF);

        // ---------------- stalled stream ----------------
        w0 = wr_cnt; d0 = done_cnt; g0 = gap_cnt;
        start_load(4, 2);
        feed(0, 8, 1'b1, ok);
        check("stall_feed_ok", ok, 1'b1);
        wait_done(lat);
        check("stall_done_seen", done, 1'b1);
        step();
        step();
        check("stall_wr_count", wr_cnt - w0, 2);
        check("stall_done_count", done_cnt - d0, 1);
        check("stall_ready_held", gap_cnt - g0, 0);
        check("stall_ram4", ram[4], 32'h1234_5678);
        check("stall_ram5", ram[5], 32'hDEAD_BEEF);

        // ---------------- address wrap ----------------
        stim = '{8'h01, 8'h00, 8'hAA, 8'hAA, 8'h02, 8'h00, 8'hAA, 8'hAA};
        w0 = wr_cnt;
        start_load(63, 2);
        feed(0, 8, 1'b0, ok);
        check("wrap_feed_ok", ok, 1'b1);
        wait_done(lat);
        check("wrap_done_seen", done, 1'b1);
        step();
        step();
        check("wrap_wr_count", wr_cnt - w0, 2);
        if (wr_cnt - w0 == 2) begin
            check("wrap_addr_first", wr_addr[w0], 63);
            check("wrap_addr_second", wr_addr[w0+1], 0);
        end
        check("wrap_ram63", ram[63], 32'hAAAA_0001);
        check("wrap_ram0", ram[0], 32'hAAAA_0002);

        // ---------------- zero length ----------------
        w0 = wr_cnt; d0 = done_cnt; b0 = br_cnt;
        start_load(9, 0);
        lat = 0;
        if (!done) wait_done(lat);
        check("zero_done_seen", done, 1'b1);
        check("zero_done_latency_ok", (lat + 1) <= 2, 1'b1);
        step();
        step();
        check("zero_idle", busy, 1'b0);
        check("zero_no_writes", wr_cnt - w0, 0);
        check("zero_no_ready", br_cnt - b0, 0);
        check("zero_done_count", done_cnt - d0, 1);

        // ---------------- start while busy ----------------
        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        w0 = wr_cnt; d0 = done_cnt;
        start_load(20, 2);
        feed(0, 2, 1'b0, ok);
        base_addr = 6'd40;
        num_words = 7'd1;
        start     = 1'b1;
        feed(2, 1, 1'b0, ok);
        start     = 1'b0;
        feed(3, 5, 1'b0, ok);
        check("busy_feed_ok", ok, 1'b1);
        wait_done(lat);
        check("busy_done_seen", done, 1'b1);
        step();
        step();
        check("busy_wr_count", wr_cnt - w0, 2);
        check("busy_done_count", done_cnt - d0, 1);
        if (wr_cnt - w0 == 2) begin
            check("busy_addr0", wr_addr[w0], 20);
            check("busy_addr1", wr_addr[w0+1], 21);
        end
        check("busy_ram20", ram[20], 32'h0403_0201);
        check("busy_ram21", ram[21], 32'h0807_0605);
        check("busy_ram40_untouched", ram[40], 32'hC0DE_0028);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Writer-side companion to distributed_ram.
- Accepts a byte stream over a valid/ready handshake and packs bytes little-endian into W-bit words.
- Writes the words to consecutive RAM addresses through distributed_ram's write channel (wr_ena/addr/wr_data).
- Used to load program and data images into instruction/data memory at runtime, instead of only through INIT files.

Parameters:
- W, 32, word width in bits; must be a multiple of 8.
- L, 64, RAM depth in words; A = $clog2(L).
- BYTES, W/8, bytes per word (derived; not overridden).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a load; sampled only in IDLE.
- base_addr  input  A  first RAM word address; latched on start.
- num_words  input  A+1  words to load, 0..2L-1; latched on start.
- byte_data  input  8  stream byte.
- byte_valid  input  1  byte_data valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- wr_ena  output  1  RAM write strobe; connect to distributed_ram wr_ena.
- addr  output  A  RAM word address.
- wr_data  output  W  RAM write data.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse at load completion.

Behaviour:
- Reset: async assert of rst_n forces state IDLE and clears all outputs (byte_ready, wr_ena, addr, wr_data, busy, done) and internal counters. Applies mid-load: the load aborts, no further writes occur, and words already written stay in RAM. Release is synchronous to clk.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - start=1 and num_words!=0: latch base_addr into the address register, clear byte_idx/word_cnt, go to COLLECT.
  - start=1 and num_words==0: go to DONE.
  - start=0: stay.
- COLLECT:
  - byte_ready=1. A byte transfers only when byte_valid && byte_ready.
  - Each accepted byte is stored in lane byte_idx, bits [8*byte_idx+7 : 8*byte_idx] (little-endian), then byte_idx increments.
  - On acceptance of byte BYTES-1: go to WRITE and reset byte_idx to 0.
  - byte_valid low: hold with no change; stalls of any length are legal.
- WRITE (exactly one cycle):
  - wr_ena=1, addr = current address, wr_data = assembled word, byte_ready=0.
  - Next cycle: address increments modulo L (L-1 wraps to 0), word_cnt increments.
  - If word_cnt+1 == num_words, go to DONE; otherwise go to COLLECT.
- DONE: done=1 for one cycle, busy=1, then go to IDLE.
- Output timing:
  - wr_ena is low outside WRITE.
  - addr and wr_data hold their last values when idle.
  - busy is low only in IDLE.
- Latency and throughput:
  - wr_ena rises the cycle after the last byte of a word is accepted.
  - done rises the cycle after the final write.
  - Peak rate is one word per BYTES+1 cycles.
- start is ignored while busy.
- num_words > L: writes wrap and overwrite earlier entries; all num_words are written.
- Writes land in distributed_ram on the WRITE-cycle clock edge. Readback is valid from the next cycle.

Decomposition:
- Shared package ram_loader_pkg: state enum (IDLE, COLLECT, WRITE, DONE) as logic [1:0]; BYTE_W=8 constant.
- Sub-module word_packer #(W):
  - Inputs: clk, rst_n, byte_data, load_en, clear.
  - Outputs: word, byte_idx, last_byte.
  - Owns lane steering and byte_idx.
- ram_loader owns the FSM, the address register, word_cnt and the handshake.

Test Plan:
- Basic load: base_addr=0, num_words=2, bytes 78 56 34 12 EF BE AD DE, byte_valid held high → exactly 2 wr_ena pulses 5 cycles apart; RAM[0]=0x12345678, RAM[1]=0xDEADBEEF; done pulses once; busy falls with done.
- Stalled stream: same data with byte_valid toggled 1,0,0,1,... → identical RAM contents; no wr_ena while a word is incomplete; byte_ready stays high in COLLECT.
- Wrap: L=64, base_addr=63, num_words=2, words 0xAAAA0001 and 0xAAAA0002 → RAM[63]=0xAAAA0001, RAM[0]=0xAAAA0002; addr reads 0 at the second wr_ena.
- Zero length: start with num_words=0 → done two cycles after start, no wr_ena, byte_ready never asserted.
- Reset mid-load: rst_n low after 6 of 8 bytes (word 0 written) → outputs 0 immediately without waiting for clk; RAM[0] keeps its new value; RAM[1] keeps its INIT value; a fresh start afterwards loads correctly.
- Start while busy: assert start with a different base_addr during COLLECT → ignored; original load completes at the original addresses.
